// File: rtl/bin_clock_timekeeper.sv
// Binary clock timekeeping core: button sync/debounce, 1 Hz prescaler,
// 24 h time-of-day counter and RUN/SET_H/SET_M/SET_S mode FSM.
module bin_clock_timekeeper #(
  parameter int CLK_DIV   = 10_000_000,
  parameter int DB_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       blink
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PSW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET_H = 2'd1,
    S_SET_M = 2'd2,
    S_SET_S = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [1:0]     w_raw;
  logic [1:0]     w_press;
  logic           w_press_mode;
  logic           w_press_inc;
  logic           w_tick;
  logic [PSW-1:0] r_presc;
  logic [4:0]     r_hours;
  logic [5:0]     r_minutes;
  logic [5:0]     r_seconds;
  logic           r_blink;

  assign w_raw = {btn_inc, btn_mode};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic           r_sync1;
    logic           r_sync2;
    logic           r_stable;
    logic           r_stable_d;
    logic [DBW-1:0] r_cnt;

    // r_cnt counts consecutive synced samples that disagree with r_stable;
    // DB_CYCLES such samples in a row commit the new level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync1    <= w_raw[g];
        r_sync2    <= r_sync1;
        r_stable_d <= r_stable;
        if (r_sync2 == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == DBW'(DB_CYCLES - 1)) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + DBW'(1);
        end
      end
    end

    assign w_press[g] = r_stable & ~r_stable_d;
  end

  assign w_press_mode = w_press[0];
  assign w_press_inc  = w_press[1];
  assign w_tick       = (r_presc == PSW'(CLK_DIV - 1));

  always_comb begin
    w_state_next = r_state;
    if (w_press_mode) begin
      case (r_state)
        S_RUN:   w_state_next = S_SET_H;
        S_SET_H: w_state_next = S_SET_M;
        S_SET_M: w_state_next = S_SET_S;
        S_SET_S: w_state_next = S_RUN;
        default: w_state_next = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RUN;
    else     r_state <= w_state_next;
  end

  // Leaving SET_S restarts the prescaler so the first running second is whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_presc <= '0;
    else if (w_press_mode && r_state == S_SET_S) r_presc <= '0;
    else if (w_tick)                             r_presc <= '0;
    else                                         r_presc <= r_presc + PSW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        if (r_seconds == 6'd59) begin
          r_seconds <= '0;
          if (r_minutes == 6'd59) begin
            r_minutes <= '0;
            r_hours   <= (r_hours == 5'd23) ? '0 : r_hours + 5'd1;
          end else begin
            r_minutes <= r_minutes + 6'd1;
          end
        end else begin
          r_seconds <= r_seconds + 6'd1;
        end
      end
    end else if (w_press_inc && !w_press_mode) begin
      case (r_state)
        S_SET_H: r_hours   <= (r_hours == 5'd23) ? '0 : r_hours + 5'd1;
        S_SET_M: r_minutes <= (r_minutes == 6'd59) ? '0 : r_minutes + 6'd1;
        S_SET_S: r_seconds <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_blink <= 1'b0;
    else if (w_press_mode)               r_blink <= 1'b0;
    else if (r_state != S_RUN && w_tick) r_blink <= ~r_blink;
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign mode     = r_state;
  assign sec_tick = w_tick;
  assign blink    = r_blink;

endmodule
